runway_mode_ctrl: RTL and testbench
===================================

RUNWAY_MODE_CTRL -- requirements
Module: runway_mode_ctrl

Interface
REQ-001 SHALL have parameter MIN_DWELL, default 4 (legal 1..15): minimum granted ticks in a direction before it may be released.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tick  input  1  one-clk step strobe from the clock divider; the only cycles where decisions are made.
REQ-005 SHALL have port hold  input  1  freeze: when 1, a tick is ignored entirely.
REQ-006 SHALL have port req_calm  input  1  level request for calm pattern; highest priority.
REQ-007 SHALL have port req_rtol  input  1  level request for right-to-left wind pattern.
REQ-008 SHALL have port req_ltor  input  1  level request for left-to-right wind pattern.
REQ-009 SHALL have port w  output  2  wind code to the lights FSM: 00 calm, 01 rtol, 10 ltor; 11 never driven.
REQ-010 SHALL have port step  output  1  one-clk enable telling the lights FSM to advance.
REQ-011 SHALL have port dir_active  output  1  1 while state is RTOL or LTOR.
REQ-012 SHALL have port dwell  output  4  current dwell count, saturating at MIN_DWELL.

Function
REQ-013 SHALL implement states CALM, RTOL, LTOR, plus a 1-bit last_grant register (RTOL/LTOR).
REQ-014 SHALL define "active tick" as tick=1 and hold=0; state, dwell, last_grant change only on active ticks.
REQ-015 SHALL register step: step=1 exactly in the cycle after an active tick, else 0; no step on hold or non-tick cycles.
REQ-016 SHALL register w and dir_active from next state: on the edge ending an active tick, w takes the new state's code in the same cycle step rises.
REQ-017 CALM transitions, on active tick: req_calm=1 -> stay CALM; req_rtol only -> RTOL; req_ltor only -> LTOR; both -> side opposite last_grant; none -> stay.
REQ-018 On each grant into RTOL/LTOR SHALL set last_grant to that side and clear dwell to 0.
REQ-019 In RTOL/LTOR, each active tick SHALL increment dwell, saturating at MIN_DWELL (no wrap).
REQ-020 dwell_met SHALL be dwell >= MIN_DWELL, evaluated on the pre-increment value.
REQ-021 RTOL SHALL move to CALM on active tick when dwell_met and (req_calm or !req_rtol or req_ltor); else stay RTOL.
REQ-022 LTOR SHALL move to CALM on active tick when dwell_met and (req_calm or !req_ltor or req_rtol); else stay LTOR.
REQ-023 SHALL never transition directly RTOL<->LTOR; every reversal passes through at least one active tick in CALM (w=00).
REQ-024 While dwell not met, requests SHALL be ignored, including req_calm.
REQ-025 In CALM, dwell SHALL hold at 0.
REQ-026 Both req_rtol and req_ltor held continuously with req_calm=0 SHALL yield alternation RTOL, CALM, LTOR, CALM, ... each direction for MIN_DWELL+1 active ticks.
REQ-027 hold asserted SHALL freeze all registers except step, which is 0.

Reset
REQ-028 On reset=1 at posedge: state CALM, w=00, step=0, dir_active=0, dwell=0, last_grant=LTOR (first tie goes to RTOL).
REQ-029 reset SHALL override tick and hold in the same cycle; reset mid-direction returns to CALM with no step pulse.

Verification
REQ-030 Reset, then 3 active ticks with no requests -> w=00 throughout, step pulses 3 times, dir_active=0.
REQ-031 req_rtol=1 held, MIN_DWELL=4 -> w=01 after first active tick; dwell 0,1,2,3,4 then holds 4; w stays 01 while req_rtol held.
REQ-032 In RTOL with dwell=2, assert req_calm -> w stays 01 until dwell=4, next active tick w=00, stays 00 while req_calm=1.
REQ-033 req_rtol=req_ltor=1 from reset -> w sequence per active tick: 01x5, 00, 10x5, 00, 01...
REQ-034 In LTOR, hold=1 for 6 cycles with tick pulsing -> no step, w/dwell unchanged; release resumes counting from frozen dwell.
REQ-035 reset=1 coincident with active tick while in LTOR dwell=3 -> next cycle w=00, step=0, dwell=0; next tie grants RTOL.

Source files
------------

// File: rtl/runway_mode_ctrl.sv
// Runway wind-mode arbiter: chooses calm / right-to-left / left-to-right on each
// divider tick and tells the lights FSM when to advance.
module runway_mode_ctrl #(
  parameter int unsigned MIN_DWELL = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       hold,
  input  logic       req_calm,
  input  logic       req_rtol,
  input  logic       req_ltor,
  output logic [1:0] w,
  output logic       step,
  output logic       dir_active,
  output logic [3:0] dwell
);

  // State encoding matches the wind code driven on w.
  typedef enum logic [1:0] {
    S_CALM = 2'b00,
    S_RTOL = 2'b01,
    S_LTOR = 2'b10
  } state_t;

  typedef enum logic {
    G_RTOL = 1'b0,
    G_LTOR = 1'b1
  } grant_t;

  localparam logic [3:0] DWELL_MAX = 4'(MIN_DWELL);

  state_t     state_q, state_d;
  grant_t     last_q, last_d;
  logic [3:0] dwell_q, dwell_d;
  logic [1:0] w_q, w_d;
  logic       step_q, step_d;
  logic       dir_q, dir_d;
  logic       active;
  logic       dwell_met;

  assign active    = tick & ~hold;
  assign dwell_met = (dwell_q >= DWELL_MAX);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    if (active) begin
      unique case (state_q)
        S_CALM: begin
          dwell_d = '0;
          if (!req_calm) begin
            // A tie goes to the side that was not granted last.
            if (req_rtol && (!req_ltor || last_q == G_LTOR)) begin
              state_d = S_RTOL;
              last_d  = G_RTOL;
            end else if (req_ltor) begin
              state_d = S_LTOR;
              last_d  = G_LTOR;
            end
          end
        end
        S_RTOL: begin
          if (dwell_met && (req_calm || !req_rtol || req_ltor)) begin
            state_d = S_CALM;
            dwell_d = '0;
          end else if (!dwell_met) begin
            dwell_d = dwell_q + 4'd1;
          end
        end
        S_LTOR: begin
          if (dwell_met && (req_calm || !req_ltor || req_rtol)) begin
            state_d = S_CALM;
            dwell_d = '0;
          end else if (!dwell_met) begin
            dwell_d = dwell_q + 4'd1;
          end
        end
        default: begin
          state_d = S_CALM;
          dwell_d = '0;
        end
      endcase
    end
    w_d    = state_d;
    dir_d  = (state_d != S_CALM);
    step_d = active;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CALM;
      last_q  <= G_LTOR;
      dwell_q <= '0;
      w_q     <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      w_q     <= w_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
    end
  end

  assign w          = w_q;
  assign step       = step_q;
  assign dir_active = dir_q;
  assign dwell      = dwell_q;

endmodule

// File: tb/tb_runway_mode_ctrl.sv
// Bench for runway_mode_ctrl: a behavioural model pushes expected outputs per
// cycle into a scoreboard queue; each scenario task pops and compares them.
module tb_runway_mode_ctrl;

  localparam int unsigned MD = 4;

  logic       clk = 1'b0;
  logic       reset, tick, hold, req_calm, req_rtol, req_ltor;
  logic [1:0] w;
  logic       step, dir_active;
  logic [3:0] dwell;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];
  logic [7:0] exp_v, got_v;

  // model state: 0 calm, 1 rtol, 2 ltor; m_last 1 means LTOR granted last
  int m_st   = 0;
  int m_last = 1;
  int m_dw   = 0;
  int m_step = 0;

  runway_mode_ctrl #(.MIN_DWELL(MD)) dut (
    .clk(clk), .reset(reset), .tick(tick), .hold(hold),
    .req_calm(req_calm), .req_rtol(req_rtol), .req_ltor(req_ltor),
    .w(w), .step(step), .dir_active(dir_active), .dwell(dwell)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, advance the model, push its expectation, sample #1 after the edge.
  task automatic cyc(input logic t, input logic h, input logic rc, input logic rr,
                     input logic rl, input logic rst);
    logic [1:0] ew;
    reset = rst; tick = t; hold = h; req_calm = rc; req_rtol = rr; req_ltor = rl;
    if (rst) begin
      m_st = 0; m_last = 1; m_dw = 0; m_step = 0;
    end else if (t && !h) begin
      m_step = 1;
      if (m_st == 0) begin
        if (!rc && rr && rl) begin
          m_st = (m_last == 1) ? 1 : 2;
          m_last = (m_st == 1) ? 0 : 1;
          m_dw = 0;
        end else if (!rc && rr) begin
          m_st = 1; m_last = 0; m_dw = 0;
        end else if (!rc && rl) begin
          m_st = 2; m_last = 1; m_dw = 0;
        end
      end else begin
        if (m_dw >= MD && (rc || (m_st == 1 ? (!rr || rl) : (!rl || rr)))) begin
          m_st = 0; m_dw = 0;
        end else if (m_dw < MD) begin
          m_dw = m_dw + 1;
        end
      end
    end else begin
      m_step = 0;
    end
    ew = (m_st == 1) ? 2'b01 : (m_st == 2) ? 2'b10 : 2'b00;
    sb.push_back({ew, m_step[0], (m_st != 0), 4'(m_dw)});
    @(posedge clk);
    #1;
    got_v = {w, step, dir_active, dwell};
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL reset: got %h expected %h", got_v, exp_v);
    end
    checks++;
    if (got_v !== 8'h00) begin
      errors++;
      $display("FAIL reset_zero: got %h expected 00", got_v);
    end
  endtask

  task automatic test_idle();
    int steps = 0;
    test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      steps += int'(step);
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL idle_tick%0d: got %h expected %h", i, got_v, exp_v);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v || step !== 1'b0) begin
        errors++;
        $display("FAIL idle_gap%0d: got %h expected %h", i, got_v, exp_v);
      end
    end
    checks++;
    if (steps != 3) begin
      errors++;
      $display("FAIL idle_step_count: got %0d expected 3", steps);
    end
  endtask

  task automatic test_rtol_dwell();
    logic [3:0] dw_tab [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4};
    test_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v || w !== 2'b01 || dwell !== dw_tab[i]) begin
        errors++;
        $display("FAIL rtol_dwell%0d: got %h expected %h (dwell %0d)", i, got_v, exp_v, dw_tab[i]);
      end
    end
  endtask

  task automatic test_calm_preempt();
    logic [1:0] w_tab [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL preempt_setup%0d: got %h expected %h", i, got_v, exp_v);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v || w !== w_tab[i]) begin
        errors++;
        $display("FAIL preempt%0d: got %h expected %h (w %b)", i, got_v, exp_v, w_tab[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] w_tab [14] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                               2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                               2'b01, 2'b01};
    test_reset();
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v || w !== w_tab[i]) begin
        errors++;
        $display("FAIL alternate%0d: got %h expected %h (w %b)", i, got_v, exp_v, w_tab[i]);
      end
    end
  endtask

  task automatic test_hold();
    test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'(i % 2 == 0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v || got_v !== {2'b10, 1'b0, 1'b1, 4'd1}) begin
        errors++;
        $display("FAIL hold%0d: got %h expected %h", i, got_v, exp_v);
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    checks++;
    if (got_v !== exp_v || dwell !== 4'd2 || step !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    checks++;
    if (dwell !== 4'd3 || w !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_setup: got w=%b dwell=%0d expected w=10 dwell=3", w, dwell);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_v = sb.pop_front();
    checks++;
    if (got_v !== exp_v || got_v !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", got_v, exp_v);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    checks++;
    if (got_v !== exp_v || w !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_tie: got %h expected %h", got_v, exp_v);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; hold = 1'b0;
    req_calm = 1'b0; req_rtol = 1'b0; req_ltor = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_rtol_dwell();
    test_calm_preempt();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
